// File: rtl/cdc_pkg.sv
// Shared types and defaults for the toggle req/ack clock-domain crossing.
// Both the launching and the capturing ends import this package.
package cdc_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } hs_state_t;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_bit_chain.sv
// Single-bit multi-flop synchronizer for a level/toggle signal.
// Synchronous active-high reset clears every stage.
module sync_bit_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic async_bit,
   output logic sync_bit
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge CLK) begin
      if (RST) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], async_bit};
      end
   end

   assign sync_bit = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Launching end of the toggle handshake: captures a word, toggles REQ_TGL,
// and waits for the synchronized acknowledge toggle to match it.
module cdc_hs_tx
   import cdc_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] SRC_DATA,
   input  logic                  SRC_VALID,
   output logic                  SRC_READY,
   output logic [DATA_WIDTH-1:0] DATA_HOLD,
   output logic                  REQ_TGL,
   input  logic                  ACK_TGL,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  PROTO_ERR
);

   hs_state_t state;
   logic      ack_s;
   logic      ack_prev;

   sync_bit_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ack_sync (
      .CLK       (CLK),
      .RST       (RST),
      .async_bit (ACK_TGL),
      .sync_bit  (ack_s)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         DATA_HOLD <= '0;
         REQ_TGL   <= 1'b0;
         ack_prev  <= 1'b0;
         DONE      <= 1'b0;
         PROTO_ERR <= 1'b0;
      end else begin
         ack_prev <= ack_s;
         DONE     <= 1'b0;
         unique case (state)
            IDLE: begin
               // an ack edge with nothing outstanding is a peer fault
               if (ack_s != ack_prev) begin
                  PROTO_ERR <= 1'b1;
               end
               if (SRC_VALID) begin
                  DATA_HOLD <= SRC_DATA;
                  REQ_TGL   <= ~REQ_TGL;
                  state     <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (ack_s == REQ_TGL) begin
                  state <= IDLE;
                  DONE  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign SRC_READY = (state == IDLE) & ~RST;
   assign BUSY      = (state == WAIT_ACK);

endmodule
